// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: sample input, batch result output and abort bundle
interface sum_accumulator_if #(
    parameter int NUM_BITS = 4,
    parameter int ACC_BITS = 6
);
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] sum;
    logic                overflow;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_BITS-1:0] total;
    logic                total_sat;
    logic [3:0]          ovf_count;
    modport master (
        output clear, in_valid, sum, overflow, out_ready,
        input  in_ready, out_valid, total, total_sat, ovf_count
    );
    modport slave (
        input  clear, in_valid, sum, overflow, out_ready,
        output in_ready, out_valid, total, total_sat, ovf_count
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: saturating sum of BATCH {overflow,sum} samples, held until handshaken
module sum_accumulator #(
    parameter int NUM_BITS = 4,
    parameter int ACC_BITS = 6,
    parameter int BATCH    = 4
) (
    input logic clk,
    input logic rst,
    sum_accumulator_if.slave bus
);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;
    // one guard bit above the wider operand so the raw sum never wraps
    localparam int W = (ACC_BITS > NUM_BITS + 1 ? ACC_BITS : NUM_BITS + 1) + 1;
    localparam logic [W-1:0] MAX = W'({ACC_BITS{1'b1}});
    logic [0:0]          state;
    logic [3:0]          count;
    logic [ACC_BITS-1:0] total;
    logic                total_sat;
    logic [3:0]          ovf_count;
    logic [W-1:0]        raw;
    logic                sat;
    logic                accept;
    logic                release_hs;
    assign accept     = state == ACCUM && bus.in_valid;
    assign release_hs = state == DONE && bus.out_ready;
    assign raw        = W'(total) + W'({bus.overflow, bus.sum});
    assign sat        = raw > MAX;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.clear || release_hs) begin
            state     <= ACCUM;
            count     <= '0;
            total     <= '0;
            total_sat <= 1'b0;
            ovf_count <= '0;
        end else if (accept) begin
            total     <= sat ? {ACC_BITS{1'b1}} : raw[ACC_BITS-1:0];
            total_sat <= total_sat | sat;
            ovf_count <= ovf_count + {3'b000, bus.overflow};
            count     <= count + 4'd1;
            state     <= count == 4'(BATCH - 1) ? DONE : ACCUM;
        end
    end
    assign bus.in_ready  = state == ACCUM;
    assign bus.out_valid = state == DONE;
    assign bus.total     = total;
    assign bus.total_sat = total_sat;
    assign bus.ovf_count = ovf_count;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: scoreboard bench for the batch sum accumulator
module tb_sum_accumulator;
    typedef struct {
        int total;
        int sat;
        int ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    res_t q[$];
    int   m_state = 0;
    int   m_cnt = 0;
    int   m_total = 0;
    int   m_sat = 0;
    int   m_ovf = 0;

    sum_accumulator_if #(.NUM_BITS(4), .ACC_BITS(6)) bus ();
    sum_accumulator #(.NUM_BITS(4), .ACC_BITS(6), .BATCH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_state = 0;
        m_cnt   = 0;
        m_total = 0;
        m_sat   = 0;
        m_ovf   = 0;
    endtask

    // reference model; pushes expected result when a batch completes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_zero();
            q.delete();
        end else if (bus.clear) begin
            model_zero();
            q.delete();
        end else if (m_state == 0 && bus.in_valid) begin
            int t;
            t = m_total + int'({bus.overflow, bus.sum});
            if (t > 63) begin
                t = 63;
                m_sat = 1;
            end
            m_total = t;
            m_ovf += int'(bus.overflow);
            m_cnt++;
            if (m_cnt == 4) begin
                m_state = 1;
                q.push_back('{m_total, m_sat, m_ovf});
            end
        end else if (m_state == 1 && bus.out_ready) begin
            if (q.size() == 0) check("sb_empty", 0, 1);
            else begin
                res_t e;
                e = q.pop_front();
                check("sb_total", bus.total, e.total);
                check("sb_sat", bus.total_sat, e.sat);
                check("sb_ovf", bus.ovf_count, e.ovf);
            end
            model_zero();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", bus.in_ready, m_state == 0);
            check("out_valid", bus.out_valid, m_state == 1);
            check("run_total", bus.total, m_total);
        end
    end

    task automatic put(input logic o, input logic [3:0] s);
        bus.in_valid = 1'b1;
        bus.overflow = o;
        bus.sum      = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic release_batch();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.overflow  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_total", bus.total, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_ovf", bus.ovf_count, 0);
        check("rst_sat", bus.total_sat, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // basic batch
        put(0, 5); put(0, 3); put(1, 2);
        check("b1_not_done", bus.out_valid, 0);
        put(0, 1);
        check("b1_valid", bus.out_valid, 1);
        check("b1_total", bus.total, 27);
        check("b1_sat", bus.total_sat, 0);
        check("b1_ovf", bus.ovf_count, 1);
        release_batch();
        check("b1_cleared", bus.total, 0);
        check("b1_in_ready", bus.in_ready, 1);
        // saturation
        put(1, 15);
        check("sat_p1", bus.total, 31);
        put(1, 15);
        check("sat_p2", bus.total, 62);
        put(1, 15);
        check("sat_p3", bus.total, 63);
        check("sat_flag3", bus.total_sat, 1);
        put(1, 15);
        check("sat_total", bus.total, 63);
        check("sat_ovf", bus.ovf_count, 4);
        // held in DONE while samples are offered
        bus.in_valid = 1'b1;
        bus.overflow = 1'b0;
        bus.sum      = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_total", bus.total, 63);
            check("hold_valid", bus.out_valid, 1);
            check("hold_ovf", bus.ovf_count, 4);
            check("hold_sat", bus.total_sat, 1);
        end
        release_batch();
        bus.in_valid = 1'b0;
        check("hold_rel_total", bus.total, 0);
        check("hold_rel_ready", bus.in_ready, 1);
        // clear beats a concurrent accept
        put(0, 5); put(0, 3);
        check("clr_pre", bus.total, 8);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.sum      = 4'd7;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_total", bus.total, 0);
        check("clr_ovf", bus.ovf_count, 0);
        // toggled in_valid; also proves the counter restarted at zero
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i % 2) == 0;
            bus.overflow = i == 4;
            bus.sum      = i == 0 ? 4'd1 : i == 2 ? 4'd2 : i == 4 ? 4'd0 : 4'd4;
            @(posedge clk);
            #1;
            if (i == 4) check("tog_not_done", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        check("tog_valid", bus.out_valid, 1);
        check("tog_total", bus.total, 23);
        check("tog_ovf", bus.ovf_count, 1);
        release_batch();
        // async reset while DONE
        put(0, 1); put(0, 1); put(0, 1); put(0, 1);
        check("ar_done", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_in_ready", bus.in_ready, 1);
        check("ar_total", bus.total, 0);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_left", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 4, giving the width of the incoming adder sum.
REQ-002 The block SHALL have parameter ACC_BITS, default 6, giving the width of the running total.
REQ-003 The block SHALL have parameter BATCH, default 4, giving the number of samples accumulated per result (range 2..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous batch abort.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream adder result is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-009 The block SHALL have port sum, input, NUM_BITS bits: the adder sum.
REQ-010 The block SHALL have port overflow, input, 1 bit: the adder carry-out.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the batch result is held.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port total, output, ACC_BITS bits: the accumulated batch total.
REQ-014 The block SHALL have port total_sat, output, 1 bit: the total saturated during the batch.
REQ-015 The block SHALL have port ovf_count, output, 4 bits: the number of samples in the batch with overflow=1.

Function
REQ-016 The block SHALL implement a two-state FSM with states ACCUM and DONE.
REQ-017 In ACCUM the block SHALL drive in_ready=1 and out_valid=0.
REQ-018 In DONE the block SHALL drive in_ready=0 and out_valid=1.
REQ-019 An input accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-020 On an accept, the sample value SHALL be the zero-extended concatenation {overflow,sum}, range 0..2^(NUM_BITS+1)-1.
REQ-021 On an accept, total SHALL become min(total+sample, 2^ACC_BITS-1), with intermediate arithmetic wide enough not to wrap.
REQ-022 On an accept, total_sat SHALL be set if the unsaturated sum exceeds 2^ACC_BITS-1, and SHALL remain set (sticky) until the batch ends.
REQ-023 On an accept with overflow=1, ovf_count SHALL increment by 1.
REQ-024 The internal sample counter SHALL increment on each accept.
REQ-025 On the accept that makes the sample count equal BATCH, the FSM SHALL go ACCUM->DONE, and out_valid SHALL be 1 in the next cycle (latency 1 edge from the last accept).
REQ-026 In DONE, total, total_sat and ovf_count SHALL be held stable until an output handshake.
REQ-027 An output handshake SHALL occur on a rising edge in DONE with out_ready=1.
REQ-028 On an output handshake, the FSM SHALL go DONE->ACCUM and clear total, total_sat, ovf_count and the counter to 0.
REQ-029 Because in_ready=0 in DONE, a sample presented in the same cycle as the output handshake SHALL NOT be accepted.
REQ-030 in_valid=1 with in_ready=0 SHALL be ignored, with no state change.
REQ-031 clear=1 at a rising edge SHALL force ACCUM with all counters and outputs zeroed, from either state.
REQ-032 clear SHALL take priority over a simultaneous input accept or output handshake; that sample or result is discarded.
REQ-033 In ACCUM, total, total_sat and ovf_count SHALL show the partial running values.
REQ-034 in_ready and out_valid SHALL be decoded from state only and SHALL NOT depend combinationally on in_valid or out_ready.

Reset
REQ-035 While rst=1, the block SHALL immediately (asynchronously) force state ACCUM, total=0, total_sat=0, ovf_count=0, counter=0, out_valid=0 and in_ready=1.
REQ-036 rst asserted mid-batch or in DONE SHALL discard all partial or held results.

Verification
REQ-037 The bench SHALL cover: samples {0,5},{0,3},{1,2},{0,1} accepted back-to-back -> out_valid=1 one edge after the 4th accept, total=27, total_sat=0, ovf_count=1.
REQ-038 The bench SHALL cover: four samples {1,15} -> partial totals 31 then 62, then saturation to 63 on the 3rd accept, holding at 63; total_sat=1, ovf_count=4.
REQ-039 The bench SHALL cover: DONE with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, no accept; then out_ready=1 -> next cycle ACCUM with total=0.
REQ-040 The bench SHALL cover: 2 accepts, then clear=1 together with in_valid=1 -> total=0, counter=0, and the concurrent sample is not counted.
REQ-041 The bench SHALL cover: rst pulsed between clock edges in DONE -> out_valid=0 and in_ready=1 before the next edge.
REQ-042 The bench SHALL cover: in_valid toggled every other cycle -> the batch completes after exactly 4 accepts, with correct totals.
